uart_rx_frame: RTL

Parametrised oversampling UART receiver with an integrated multi-byte frame assembler.
- Receives NBYTES characters of DBIT data bits each.
- Presents them as one wide word under a valid/ready handshake, and reports framing and parity errors.
- Sits between the pad-side serial line and the command/ALU front end; generalises the fixed 8-bit, 3-byte calculator receiver.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 148 ++++++++++++++
 rtl/uart_rx_frame.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : receiver state encoding and parity-sense constants
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    HOLD  = 3'd5
  } rx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
//------------------------------------------------------------------------------
// uart_rx_byte : rxd synchroniser and oversampled bit engine (IDLE..STOP)
// Optional parity bit when UART_RX_PARITY_EN is defined.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            tick,
  input  logic            rxd,
  input  logic            hold,
  output logic [DBIT-1:0] byte_data,
  output logic            byte_valid,
  output logic            frame_err,
  output logic            par_err,
  output logic            busy
);

  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DBIT + 1);
  localparam logic [OW-1:0] c_half     = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] c_full     = OW'(OVS - 1);
  localparam logic [BW-1:0] c_last_bit = BW'(DBIT - 1);

  logic [1:0]      r_sync;
  logic            w_rxd_s;
  rx_state_t       r_state, w_state_nxt;
  logic [OW-1:0]   r_ov, w_ov_nxt;
  logic [BW-1:0]   r_bit, w_bit_nxt;
  logic [DBIT-1:0] r_shift, w_shift_nxt;
  logic            r_par_bad, w_par_bad_nxt;

  assign w_rxd_s = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_state   <= IDLE;
      r_ov      <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rxd};
      r_state   <= w_state_nxt;
      r_ov      <= w_ov_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bad <= w_par_bad_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ov_nxt      = r_ov;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    byte_valid    = 1'b0;
    frame_err     = 1'b0;
    par_err       = 1'b0;
    if (!en) begin
      w_state_nxt   = IDLE;
      w_ov_nxt      = '0;
      w_bit_nxt     = '0;
      w_par_bad_nxt = 1'b0;
    end else if (tick) begin
      case (r_state)
        IDLE: begin
          // hold keeps the engine parked while a finished frame awaits hand-off
          if (!hold && !w_rxd_s) begin
            w_state_nxt = START;
            w_ov_nxt    = '0;
          end
        end
        START: begin
          if (r_ov == c_half) begin
            w_ov_nxt    = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rxd_s ? IDLE : DATA;
          end else begin
            w_ov_nxt = r_ov + 1'b1;
          end
        end
        DATA: begin
          if (r_ov == c_full) begin
            w_shift_nxt = {w_rxd_s, r_shift[DBIT-1:1]};
            w_ov_nxt    = '0;
            w_bit_nxt   = r_bit + 1'b1;
            if (r_bit == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PAR;
`else
              w_state_nxt = STOP;
`endif
            end
          end else begin
            w_ov_nxt = r_ov + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PAR: begin
          if (r_ov == c_full) begin
            w_par_bad_nxt = (w_rxd_s != ((^r_shift) ^ (PARITY_ODD != 0)));
            w_ov_nxt      = '0;
            w_state_nxt   = STOP;
          end else begin
            w_ov_nxt = r_ov + 1'b1;
          end
        end
`endif
        STOP: begin
          if (r_ov == c_full) begin
            frame_err     = !w_rxd_s;
            par_err       = r_par_bad;
            byte_valid    = w_rxd_s && !r_par_bad;
            w_par_bad_nxt = 1'b0;
            w_ov_nxt      = '0;
            w_state_nxt   = IDLE;
          end else begin
            w_ov_nxt = r_ov + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  logic w_unused_par;
  assign w_unused_par = (PARITY_ODD != 0);
`endif

  assign byte_data = r_shift;
  assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
//------------------------------------------------------------------------------
// uart_rx_frame : oversampling UART receiver assembling NBYTES chars per frame
// Parity support compiled in with UART_RX_PARITY_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int NBYTES     = 3,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       tick,
  input  logic                       rxd,
  output logic [NBYTES*DBIT-1:0]     frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       frame_err,
  output logic                       par_err,
  output logic                       busy,
  output logic [$clog2(NBYTES)-1:0]  byte_cnt
);

  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] c_last_slot = CW'(NBYTES - 1);

  logic [DBIT-1:0]        w_byte;
  logic                   w_byte_valid, w_ferr, w_perr, w_rx_busy;
  logic [DBIT-1:0]        r_slots [NBYTES-1];
  logic [NBYTES*DBIT-1:0] w_frame_nxt;
  logic [NBYTES*DBIT-1:0] r_frame_data;
  logic                   r_valid, r_frame_err, r_par_err;
  logic [CW-1:0]          r_cnt;

  uart_rx_byte #(
    .DBIT       (DBIT),
    .OVS        (OVS),
    .PARITY_ODD (PARITY_ODD)
  ) u_byte (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .tick       (tick),
    .rxd        (rxd),
    .hold       (r_valid),
    .byte_data  (w_byte),
    .byte_valid (w_byte_valid),
    .frame_err  (w_ferr),
    .par_err    (w_perr),
    .busy       (w_rx_busy)
  );

  // Slots below the last; the last character goes straight into the frame word
  for (genvar i = 0; i < NBYTES - 1; i++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_slots[i] <= '0;
      else if (w_byte_valid && r_cnt == CW'(i))
        r_slots[i] <= w_byte;
    end
    assign w_frame_nxt[i*DBIT +: DBIT] = r_slots[i];
  end
  assign w_frame_nxt[(NBYTES-1)*DBIT +: DBIT] = w_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_data <= '0;
      r_valid      <= 1'b0;
      r_cnt        <= '0;
      r_frame_err  <= 1'b0;
      r_par_err    <= 1'b0;
    end else if (!en) begin
      r_valid     <= 1'b0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_par_err   <= w_perr;
      if (w_ferr || w_perr) begin
        r_cnt <= '0;
      end else if (w_byte_valid) begin
        if (r_cnt == c_last_slot) begin
          r_cnt        <= '0;
          r_valid      <= 1'b1;
          r_frame_data <= w_frame_nxt;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_valid = r_valid;
  assign frame_err   = r_frame_err;
  assign par_err     = r_par_err;
  assign byte_cnt    = r_cnt;
  assign busy        = w_rx_busy | r_valid;

endmodule

`default_nettype wire
